// File: rtl/serial_add_sequencer_if.sv
// Bundle of the request/result handshake and the bit-level link to the
// external 1-bit full-adder cell. The sequencer takes the slave view. The
// master view is everything around it: the requester plus the adder cell.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             add_a;
  logic             add_b;
  logic             add_cin;
  logic             add_sumout;
  logic             add_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in, cin_in, add_sumout, add_cout,
    input  add_a, add_b, add_cin, busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in, add_sumout, add_cout,
    output add_a, add_b, add_cin, busy, done, sum_out, cout_out
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer. It feeds two operands LSB-first through an
// external 1-bit full-adder cell, recirculates the cell's carry, and
// assembles the WIDTH-bit sum plus the final carry. One addition takes
// WIDTH+2 cycles: accept, WIDTH bit steps, then one DONE cycle.
module serial_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_carry;
  logic             r_cout_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_add_a;
  logic             w_add_b;
  logic             w_add_cin;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_sum_nxt;

  // The cell's sum bit enters at the MSB. After WIDTH steps the first
  // (LSB) sum bit has reached bit 0.
  assign w_sum_nxt = {bus.add_sumout, r_sum_sh[WIDTH-1:1]};

  // Next-state and output decode. Adder inputs are driven only in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_add_a     = 1'b0;
    w_add_b     = 1'b0;
    w_add_cin   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_add_a   = r_a_sh[0];
        w_add_b   = r_b_sh[0];
        w_add_cin = r_carry;
        w_busy    = 1'b1;
        w_step    = 1'b1;
        if (r_cnt == LP_CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. Reset overrides everything, including a RUN in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand/sum shifting and result capture. The cell outputs are sampled
  // only on RUN edges, so they may be X at any other time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_load) begin
      r_a_sh   <= bus.a_in;
      r_b_sh   <= bus.b_in;
      r_carry  <= bus.cin_in;
      r_sum_sh <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_nxt;
      r_carry  <= bus.add_cout;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum_out  <= w_sum_nxt;
        r_cout_out <= bus.add_cout;
      end
    end
  end

  assign bus.add_a    = w_add_a;
  assign bus.add_b    = w_add_b;
  assign bus.add_cin  = w_add_cin;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.sum_out  = r_sum_out;
  assign bus.cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with WIDTH=8. A behavioural
// 1-bit full-adder cell is attached to the add_* signals.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 1-bit full-adder cell
  assign bus.add_sumout = bus.add_a ^ bus.add_b ^ bus.add_cin;
  assign bus.add_cout   = (bus.add_a & bus.add_b) | (bus.add_a & bus.add_cin) |
                          (bus.add_b & bus.add_cin);

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One addition with garbage on the operand inputs after the accept edge.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] exp_s, input logic exp_c,
                         input logic chk_cin1);
    int   k;
    logic seen;
    logic all_cin;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = c;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen      = 1'b0;
    all_cin   = 1'b1;
    k         = 0;
    while (!seen && k < 20) begin
      if (bus.busy && !bus.done) all_cin = all_cin & bus.add_cin;
      bus.a_in   = 8'($urandom);
      bus.b_in   = 8'($urandom);
      bus.cin_in = 1'($urandom);
      @(posedge clk); #1;
      k++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_latency_edges"}, 32'(k), WIDTH);
    chk({tag, "_sum"}, 32'(bus.sum_out), 32'(exp_s));
    chk({tag, "_cout"}, 32'(bus.cout_out), 32'(exp_c));
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 1);
    if (chk_cin1) chk({tag, "_cin_all_ones"}, 32'(all_cin), 1);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(bus.done), 0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_sum_hold"}, 32'(bus.sum_out), 32'(exp_s));
  endtask

  initial begin
    int         last_acc;
    int         n_acc;
    int         k;
    logic       prev_busy;
    logic       done_seen;
    logic [8:0] exp_q;
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum", 32'(bus.sum_out), 0);
    chk("rst_cout", 32'(bus.cout_out), 0);
    chk("rst_add_a", 32'(bus.add_a), 0);
    chk("rst_add_b", 32'(bus.add_b), 0);
    chk("rst_add_cin", 32'(bus.add_cin), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_add("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_add("chain", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    run_add("max",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start held high with operands changing every cycle
    last_acc  = -1;
    n_acc     = 0;
    exp_q     = '0;
    prev_busy = bus.busy;
    for (int c = 0; c < 40; c++) begin
      va         = 8'(c * 37 + 5);
      vb         = 8'(c * 91 + 3);
      vc         = c[0];
      bus.a_in   = va;
      bus.b_in   = vb;
      bus.cin_in = vc;
      bus.start  = (c <= 35);
      @(posedge clk); #1;
      if (!prev_busy && bus.busy) begin
        if (n_acc > 0) chk("held_accept_gap", 32'(c - last_acc), 10);
        last_acc = c;
        n_acc++;
        exp_q = 9'(va) + 9'(vb) + 9'(vc);
      end
      if (bus.done) begin
        chk("held_sum", 32'(bus.sum_out), 32'(exp_q[7:0]));
        chk("held_cout", 32'(bus.cout_out), 32'(exp_q[8]));
      end
      prev_busy = bus.busy;
    end
    chk("held_accept_count", 32'(n_acc), 4);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // reset in the 4th RUN cycle
    bus.a_in   = 8'h0F;
    bus.b_in   = 8'hF1;
    bus.cin_in = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_sum", 32'(bus.sum_out), 0);
    chk("midrst_cout", 32'(bus.cout_out), 0);
    chk("midrst_add_a", 32'(bus.add_a), 0);
    chk("midrst_add_b", 32'(bus.add_b), 0);
    chk("midrst_add_cin", 32'(bus.add_cin), 0);
    done_seen = 1'b0;
    for (k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    chk("midrst_no_done", 32'(done_seen), 0);

    run_add("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial sequencer wrapped around the 1-bit full-adder cell.
- Upstream side: loads two WIDTH-bit operands and feeds them LSB-first into the cell's a/b/cin inputs.
- Downstream side: captures the cell's sumout/cout each cycle, recirculates cout as the next cin, and assembles the WIDTH-bit sum plus final carry.
- Lets the architecture library build multi-bit addition from a single hard adder bit for characterisation and netlist tests.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured on the accepting edge.
- b_in  input  WIDTH  operand B, captured on the accepting edge.
- cin_in  input  1  initial carry-in, captured on the accepting edge.
- add_a  output  1  to adder cell input a.
- add_b  output  1  to adder cell input b.
- add_cin  output  1  to adder cell input cin.
- add_sumout  input  1  from adder cell sumout.
- add_cout  input  1  from adder cell cout.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- sum_out  output  WIDTH  assembled sum.
- cout_out  output  1  final carry.

Behaviour:
- Reset (rst high at an edge): state=IDLE, counter=0, operand shift registers=0, carry reg=0, sum_out=0, cout_out=0, busy=0, done=0.
  - Reset wins over every other input, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sh=a_in, b_sh=b_in, carry=cin_in, clear sum shift reg, counter=0, go to RUN.
  - start=0: stay in IDLE; sum_out/cout_out hold the last result.
- RUN:
  - add_a=a_sh[0], add_b=b_sh[0], add_cin=carry, all combinational from registers.
  - Outside RUN, add_a/add_b/add_cin are forced to 0.
  - The adder cell is combinational; its outputs are sampled in the same cycle.
  - Each edge:
    - sum shift reg shifts right with add_sumout entering the MSB.
    - carry=add_cout.
    - a_sh and b_sh shift right, filling with 0.
    - counter increments.
  - When counter==WIDTH-1 at the edge: sum_out=final shifted value, cout_out=add_cout, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- busy=1 in RUN and DONE, 0 in IDLE.
- start outside IDLE is ignored: no queuing, no restart.
- Latency: start accepted at edge E0; bits processed at edges E1..EWIDTH; done high in the cycle after EWIDTH.
  - Earliest next accept is the edge after done, so throughput is one addition per WIDTH+2 cycles.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin_in, modulo 2^(WIDTH+1); no overflow signalling beyond cout_out.
- sum_out and cout_out update only on the RUN→DONE edge; they are stable from done until the next completion or reset.
- Operand inputs are ignored except on the accepting edge; changing them mid-RUN has no effect.
- X on add_sumout/add_cout is never sampled outside RUN.

Test Plan:
- All scenarios: WIDTH=8, bench instantiates the 1-bit full-adder cell on the add_* ports.
- Reset: assert rst 2 cycles → busy=0, done=0, sum_out=0x00, cout_out=0, add_a/add_b/add_cin=0.
- Basic add: a_in=0x35, b_in=0x4A, cin_in=0, start 1 cycle → done pulses exactly 9 cycles after the accept edge's cycle (EWIDTH+1); sum_out=0x7F, cout_out=0.
- Carry chain and overflow: a_in=0xFF, b_in=0x00, cin_in=1 → sum_out=0x00, cout_out=1.
  - add_cin=1 on every RUN cycle.
- Max operands: a_in=0xFF, b_in=0xFF, cin_in=1 → sum_out=0xFF, cout_out=1.
- start held high continuously, operands changing every cycle:
  - Only IDLE-edge values are used.
  - Results equal the reference sum of the captured values.
  - Accepts are spaced exactly 10 cycles apart.
- rst asserted on the 4th RUN cycle of a_in=0x0F, b_in=0xF1 → next cycle IDLE, all outputs 0, no done pulse.
  - A following start with a_in=0x01, b_in=0x01 yields sum_out=0x02, cout_out=0.
